bit_index_sequencer: RTL and testbench
======================================

BIT_INDEX_SEQUENCER -- requirements
Module: bit_index_sequencer

Interface
REQ-001 The block SHALL have parameter BITS_WIDTH, default 4, mask width; legal range 2..64.
REQ-002 The block SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port s_valid, input, 1, mask offered.
REQ-005 The block SHALL have port s_ready, output, 1, mask accepted when s_valid&&s_ready.
REQ-006 The block SHALL have port s_bits, input, BITS_WIDTH, mask to enumerate.
REQ-007 The block SHALL have port m_valid, output, 1, index valid.
REQ-008 The block SHALL have port m_ready, input, 1, index consumed when m_valid&&m_ready.
REQ-009 The block SHALL have port m_index, output, $clog2(BITS_WIDTH), position of current set bit.
REQ-010 The block SHALL have port m_last, output, 1, current index is the highest set bit of the mask.
REQ-011 The block SHALL have port m_count, output, $clog2(BITS_WIDTH)+1, popcount of the mask being enumerated.
REQ-012 The block SHALL have port empty_drop, output, 1, one-cycle pulse on acceptance of an all-zero mask.

Function
REQ-013 The FSM SHALL have two states: IDLE and EMIT.
REQ-014 In IDLE, s_ready SHALL be 1 and m_valid SHALL be 0.
REQ-015 In IDLE, acceptance of a nonzero mask SHALL latch it into a remaining register, latch its popcount into m_count, and enter EMIT.
REQ-016 In IDLE, acceptance of an all-zero mask SHALL pulse empty_drop for exactly one cycle and stay in IDLE.
REQ-017 In EMIT, m_valid SHALL be 1 and m_index SHALL equal the lowest set bit position of remaining.
REQ-018 In EMIT, m_last SHALL be 1 iff remaining has exactly one bit set.
REQ-019 On an m_valid&&m_ready handshake, the lowest set bit of remaining SHALL be cleared.
REQ-020 On the m_last handshake, the FSM SHALL return to IDLE, except as allowed by REQ-028.
REQ-021 While m_valid=1 and m_ready=0, m_index, m_last and m_count SHALL hold stable.
REQ-022 First index latency SHALL be 1 cycle: mask accepted at edge N gives m_valid at edge N+1.
REQ-023 Throughput SHALL be one index per cycle while m_ready=1.
REQ-024 m_* outputs SHALL be driven only from registered state, with no combinational path from s_* to m_*.
REQ-025 Indices SHALL be emitted in strictly ascending order, and popcount(mask) handshakes SHALL occur per mask.

Reset
REQ-026 On reset assertion, asynchronously: state=IDLE, remaining=0, m_count=0, m_valid=0, m_last=0, m_index=0, empty_drop=0, and s_ready=0 while reset is high.
REQ-027 Reset asserted mid-EMIT SHALL discard the partially enumerated mask; after reset release the first accepted mask SHALL start fresh.

Configuration
REQ-028 With macro BIT_INDEX_SEQ_PREFETCH_EN defined, s_ready SHALL also be 1 in EMIT when m_last&&m_ready; a nonzero mask accepted then SHALL load directly and EMIT SHALL continue with no bubble, while an all-zero mask SHALL pulse empty_drop and go to IDLE.
REQ-029 Without BIT_INDEX_SEQ_PREFETCH_EN, s_ready SHALL be 1 only in IDLE, giving a minimum one-cycle m_valid gap between consecutive masks.

Verification
REQ-030 The bench SHALL cover: BITS_WIDTH=4, s_bits=4'b1010, m_ready=1 -> m_index 1 then 3; m_last only on 3; m_count=2; m_valid exactly 2 cycles starting N+1.
REQ-031 The bench SHALL cover: s_bits=4'b0000 accepted -> empty_drop high exactly 1 cycle; m_valid stays 0; state IDLE.
REQ-032 The bench SHALL cover: s_bits=4'b1111, m_ready toggling 1,0,0,1,1,0,1 -> indices 0,1,2,3 in order; outputs stable during stalls; m_last on 3; m_count=4.
REQ-033 The bench SHALL cover: back-to-back masks 4'b0001 then 4'b1000, m_ready=1 -> without macro, index 0, one idle cycle, then index 3; with macro, index 0 then index 3 on consecutive cycles.
REQ-034 The bench SHALL cover: s_bits=4'b0111, reset asserted after index 0 handshake -> all outputs reset immediately; after release, mask 4'b0100 yields only index 2 with m_last=1 and m_count=1.
REQ-035 The bench SHALL cover: BITS_WIDTH=8, s_bits=8'h81 -> m_index 0 then 7; m_count=2; m_last on 7.

Source files
------------

// File: rtl/bit_index_sequencer.sv
// Enumerates the set-bit positions of an accepted mask, lowest first, one index per handshake.
// Optional macro BIT_INDEX_SEQ_PREFETCH_EN lets the next mask load on the final handshake with no bubble.
module bit_index_sequencer #(
   parameter int BITS_WIDTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [BITS_WIDTH-1:0]         s_bits,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [$clog2(BITS_WIDTH)-1:0] m_index,
   output logic                          m_last,
   output logic [$clog2(BITS_WIDTH):0]   m_count,
   output logic                          empty_drop
);

   localparam int IDX_W = $clog2(BITS_WIDTH);
   localparam int CNT_W = IDX_W + 1;
   localparam logic [BITS_WIDTH-1:0] ONE = BITS_WIDTH'(1);

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [BITS_WIDTH-1:0] remaining_q, remaining_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  drop_q, drop_d;
   logic                  accept;

   function automatic logic [CNT_W-1:0] popcount(input logic [BITS_WIDTH-1:0] v);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < BITS_WIDTH; i++) begin
         n = n + CNT_W'(v[i]);
      end
      return n;
   endfunction

   // Scanning downward leaves the lowest set position as the final assignment.
   function automatic logic [IDX_W-1:0] lowest_index(input logic [BITS_WIDTH-1:0] v);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = BITS_WIDTH - 1; i >= 0; i--) begin
         if (v[i]) begin
            idx = IDX_W'(i);
         end
      end
      return idx;
   endfunction

   function automatic logic [BITS_WIDTH-1:0] clear_lowest(input logic [BITS_WIDTH-1:0] v);
      return v & (v - ONE);
   endfunction

   function automatic logic single_bit(input logic [BITS_WIDTH-1:0] v);
      return (v != '0) && (clear_lowest(v) == '0);
   endfunction

   // Index outputs are decoded from the registered remaining mask only.
   assign m_valid    = (state_q == EMIT);
   assign m_index    = lowest_index(remaining_q);
   assign m_last     = single_bit(remaining_q);
   assign m_count    = count_q;
   assign empty_drop = drop_q;

`ifdef BIT_INDEX_SEQ_PREFETCH_EN
   assign s_ready = !reset && ((state_q == IDLE) || ((state_q == EMIT) && m_last && m_ready));
`else
   assign s_ready = !reset && (state_q == IDLE);
`endif

   assign accept = s_valid && s_ready;

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      count_d     = count_q;
      drop_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (s_bits != '0) begin
                  remaining_d = s_bits;
                  count_d     = popcount(s_bits);
                  state_d     = EMIT;
               end else begin
                  drop_d = 1'b1;
               end
            end
         end
         EMIT: begin
            if (m_ready) begin
               remaining_d = clear_lowest(remaining_q);
               if (m_last) begin
                  state_d = IDLE;
`ifdef BIT_INDEX_SEQ_PREFETCH_EN
                  // Final handshake doubles as the load slot for the next mask.
                  if (accept) begin
                     if (s_bits != '0) begin
                        remaining_d = s_bits;
                        count_d     = popcount(s_bits);
                        state_d     = EMIT;
                     end else begin
                        drop_d = 1'b1;
                     end
                  end
`endif
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         count_q     <= '0;
         drop_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         count_q     <= count_d;
         drop_q      <= drop_d;
      end
   end

   // Embedded protocol properties.
   a_hold_on_stall: assert property (@(posedge clk) disable iff (reset)
      (m_valid && !m_ready) |=> (m_valid && $stable(m_index) && $stable(m_last) && $stable(m_count)));

   a_drop_pulse: assert property (@(posedge clk) disable iff (reset)
      (s_valid && s_ready && (s_bits == '0)) |=> (empty_drop && !m_valid));

   a_emit_nonzero: assert property (@(posedge clk) disable iff (reset)
      m_valid |-> (remaining_q != '0));

endmodule

// File: tb/tb_bit_index_sequencer.sv
// Scoreboard bench for bit_index_sequencer: widths 4 and 8, directed cases plus randomized masks and back-pressure.
module tb_bit_index_sequencer;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic       s_valid4, s_ready4, m_valid4, m_ready4, m_last4, empty_drop4;
   logic [3:0] s_bits4;
   logic [1:0] m_index4;
   logic [2:0] m_count4;

   logic       s_valid8, s_ready8, m_valid8, m_ready8, m_last8, empty_drop8;
   logic [7:0] s_bits8;
   logic [2:0] m_index8;
   logic [3:0] m_count8;

   bit_index_sequencer #(.BITS_WIDTH(4)) dut4 (
      .clk(clk), .reset(reset),
      .s_valid(s_valid4), .s_ready(s_ready4), .s_bits(s_bits4),
      .m_valid(m_valid4), .m_ready(m_ready4), .m_index(m_index4),
      .m_last(m_last4), .m_count(m_count4), .empty_drop(empty_drop4)
   );

   bit_index_sequencer #(.BITS_WIDTH(8)) dut8 (
      .clk(clk), .reset(reset),
      .s_valid(s_valid8), .s_ready(s_ready8), .s_bits(s_bits8),
      .m_valid(m_valid8), .m_ready(m_ready8), .m_index(m_index8),
      .m_last(m_last8), .m_count(m_count8), .empty_drop(empty_drop8)
   );

   typedef struct {
      int idx;
      int last;
      int cnt;
   } exp_t;

   exp_t q4[$];
   exp_t q8[$];
   int   hs4[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   valid4 = 0;
   int   drop4 = 0;
   int   drop8 = 0;
   int   exp_drop4 = 0;
   int   exp_drop8 = 0;
   bit   done4 = 1'b0;
   bit   done8 = 1'b0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: a mask yields its set positions in ascending order, the final one flagged last.
   task automatic push_model(input bit sel, input logic [7:0] mask);
      int w, n, k;
      exp_t e;
      w = sel ? 8 : 4;
      n = 0;
      for (int i = 0; i < w; i++) if (mask[i]) n++;
      k = 0;
      for (int i = 0; i < w; i++) begin
         if (mask[i]) begin
            k++;
            e.idx  = i;
            e.last = (k == n) ? 1 : 0;
            e.cnt  = n;
            if (sel) q8.push_back(e);
            else q4.push_back(e);
         end
      end
      if (n == 0) begin
         if (sel) exp_drop8++;
         else exp_drop4++;
      end
   endtask

   // Offers a mask and returns just after the accepting edge with s_valid still raised.
   task automatic send(input bit sel, input logic [7:0] mask);
      bit ok;
      ok = 1'b0;
      if (sel) begin
         s_valid8 = 1'b1;
         s_bits8  = mask;
      end else begin
         s_valid4 = 1'b1;
         s_bits4  = mask[3:0];
      end
      for (int t = 0; t < 100 && !ok; t++) begin
         @(negedge clk);
         if (sel ? s_ready8 : s_ready4) begin
            ok = 1'b1;
            push_model(sel, sel ? mask : {4'b0000, mask[3:0]});
         end
         @(posedge clk);
         #1;
      end
      check(sel ? "accept8" : "accept4", ok, 1);
   endtask

   task automatic drain();
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 300 && !ok; t++) begin
         tick();
         if (q4.size() == 0 && q8.size() == 0 && !m_valid4 && !m_valid8) ok = 1'b1;
      end
      check("drain", ok, 1);
   endtask

   initial begin : mon4
      bit   stall;
      int   pidx, plast, pcnt;
      exp_t e;
      stall = 1'b0;
      pidx = 0; plast = 0; pcnt = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            stall = 1'b0;
         end else begin
            if (m_valid4) valid4++;
            if (empty_drop4) drop4++;
            if (stall) begin
               check("stall_valid4", m_valid4, 1);
               check("stall_index4", m_index4, pidx);
               check("stall_last4", m_last4, plast);
               check("stall_count4", m_count4, pcnt);
            end
            if (m_valid4 && m_ready4) begin
               hs4.push_back(cyc);
               if (q4.size() == 0) begin
                  check("sb4_unexpected_index", q4.size(), 1);
               end else begin
                  e = q4.pop_front();
                  check("sb4_index", m_index4, e.idx);
                  check("sb4_last", m_last4, e.last);
                  check("sb4_count", m_count4, e.cnt);
               end
            end
            stall = m_valid4 && !m_ready4;
            pidx  = m_index4;
            plast = m_last4;
            pcnt  = m_count4;
         end
      end
   end

   initial begin : mon8
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (empty_drop8) drop8++;
            if (m_valid8 && m_ready8) begin
               if (q8.size() == 0) begin
                  check("sb8_unexpected_index", q8.size(), 1);
               end else begin
                  e = q8.pop_front();
                  check("sb8_index", m_index8, e.idx);
                  check("sb8_last", m_last8, e.last);
                  check("sb8_count", m_count8, e.cnt);
               end
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   initial begin : stim
      int   v0, d0, n0;
      bit   pat [7];
      logic [7:0] m;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      s_valid4 = 1'b0; s_bits4 = '0; m_ready4 = 1'b0;
      s_valid8 = 1'b0; s_bits8 = '0; m_ready8 = 1'b0;

      // Reset state, observed between clock edges.
      #1 reset = 1'b1;
      #2;
      check("rst_m_valid4", m_valid4, 0);
      check("rst_s_ready4", s_ready4, 0);
      check("rst_m_index4", m_index4, 0);
      check("rst_m_last4", m_last4, 0);
      check("rst_m_count4", m_count4, 0);
      check("rst_empty_drop4", empty_drop4, 0);
      check("rst_m_valid8", m_valid8, 0);
      check("rst_s_ready8", s_ready8, 0);
      check("rst_m_count8", m_count8, 0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      tick();
      check("idle_s_ready4", s_ready4, 1);

      // 1010 with m_ready held: indices 1,3; exactly two valid cycles from the next edge.
      m_ready4 = 1'b1;
      v0 = valid4;
      send(0, 8'h0A);
      check("lat_1010_m_valid", m_valid4, 1);
      s_valid4 = 1'b0;
      drain();
      check("vcycles_1010", valid4 - v0, 2);

      // All-zero mask: single empty_drop pulse, no indices, stays idle.
      v0 = valid4;
      d0 = drop4;
      send(0, 8'h00);
      s_valid4 = 1'b0;
      repeat (3) tick();
      check("zero_drop_cycles", drop4 - d0, 1);
      check("zero_vcycles", valid4 - v0, 0);
      check("zero_idle_ready", s_ready4, 1);

      // 1111 under a stall pattern.
      v0 = valid4;
      n0 = hs4.size();
      send(0, 8'h0F);
      s_valid4 = 1'b0;
      for (int i = 0; i < 7; i++) begin
         m_ready4 = pat[i];
         tick();
      end
      m_ready4 = 1'b1;
      drain();
      check("stall_vcycles", valid4 - v0, 7);
      check("stall_handshakes", hs4.size() - n0, 4);

      // Back-to-back 0001 then 1000.
      n0 = hs4.size();
      send(0, 8'h01);
      send(0, 8'h08);
      s_valid4 = 1'b0;
      drain();
      check("b2b_handshakes", hs4.size() - n0, 2);
      if (hs4.size() - n0 >= 2) begin
`ifdef BIT_INDEX_SEQ_PREFETCH_EN
         check("b2b_gap", hs4[n0 + 1] - hs4[n0], 1);
`else
         check("b2b_gap", hs4[n0 + 1] - hs4[n0], 2);
`endif
      end

      // Reset mid-enumeration of 0111 after the index-0 handshake.
      n0 = hs4.size();
      send(0, 8'h07);
      s_valid4 = 1'b0;
      tick();
      check("mid_first_handshake", hs4.size() - n0, 1);
      reset = 1'b1;
      #1;
      check("mid_rst_m_valid", m_valid4, 0);
      check("mid_rst_m_index", m_index4, 0);
      check("mid_rst_m_last", m_last4, 0);
      check("mid_rst_m_count", m_count4, 0);
      check("mid_rst_empty_drop", empty_drop4, 0);
      check("mid_rst_s_ready", s_ready4, 0);
      q4.delete();
      repeat (2) tick();
      reset = 1'b0;
      tick();
      n0 = hs4.size();
      send(0, 8'h04);
      s_valid4 = 1'b0;
      drain();
      check("post_rst_handshakes", hs4.size() - n0, 1);

      // Width 8: 0x81 gives indices 0 and 7.
      m_ready8 = 1'b1;
      send(1, 8'h81);
      s_valid8 = 1'b0;
      drain();

      // Randomized masks with random gaps and back-pressure on both instances.
      fork
         begin
            logic [7:0] r4;
            for (int i = 0; i < 40; i++) begin
               r4 = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(0, 15));
               send(0, r4);
               if ($urandom_range(0, 2) == 0) begin
                  s_valid4 = 1'b0;
                  repeat ($urandom_range(1, 3)) tick();
               end
            end
            s_valid4 = 1'b0;
            done4 = 1'b1;
         end
         begin
            logic [7:0] r8;
            for (int i = 0; i < 25; i++) begin
               r8 = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
               send(1, r8);
               if ($urandom_range(0, 2) == 0) begin
                  s_valid8 = 1'b0;
                  repeat ($urandom_range(1, 3)) tick();
               end
            end
            s_valid8 = 1'b0;
            done8 = 1'b1;
         end
         begin
            while (!(done4 && done8)) begin
               m_ready4 = ($urandom_range(0, 3) != 0);
               m_ready8 = ($urandom_range(0, 3) != 0);
               tick();
            end
         end
      join
      m_ready4 = 1'b1;
      m_ready8 = 1'b1;
      drain();
      m = 8'h00;
      repeat (2) tick();
      check("total_drops4", drop4, exp_drop4);
      check("total_drops8", drop8, exp_drop8);
      check("final_idle_ready8", s_ready8, 1);
      check("final_q4_empty", q4.size(), m);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
